restador_serial8b: RTL and testbench
====================================

Name: restador_serial8b

Overview:
- Bit-serial subtractor that computes i_minuendo - i_sustraendo - i_borrow, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Sequential counterpart of the combinational ripple adders in the arithmetic library; it trades latency for area.
- Used by small datapaths that can tolerate a WIDTH+1 cycle result.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  request; sampled only in IDLE.
- i_minuendo  in  WIDTH  minuend A.
- i_sustraendo  in  WIDTH  subtrahend B.
- i_borrow  in  1  borrow-in; the block subtracts it as an extra 1.
- o_resta  out  WIDTH  difference A-B-bin mod 2^WIDTH; valid from o_done until the next accepted start.
- o_borrow  out  1  borrow-out; 1 when A < B+bin (unsigned).
- o_busy  out  1  high while state != IDLE.
- o_done  out  1  one-cycle pulse; result valid.

Behaviour:
- Interface: one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset: state=IDLE. o_resta, o_borrow, o_busy and o_done are all 0. Counter and shift registers are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On i_start=1 at edge k, latch A, B and bin into shift registers, set cnt=0, go to RUN.
  - o_resta and o_borrow keep their previous values until this edge.
  - In the cycle after acceptance, o_resta is cleared to 0 and o_borrow to 0; both are undefined-free and must not be sampled.
- RUN:
  - Each edge computes d = a0^b0^br and br' = (~a0&b0)|(~(a0^b0)&br).
  - d shifts into result MSB, result shifts right, A and B shift right, br <= br', cnt++.
  - After WIDTH RUN edges (cnt==WIDTH-1 at the edge), go to DONE.
- DONE:
  - o_done=1 for exactly one cycle; o_resta/o_borrow are valid; next edge goes to IDLE.
- Latency: start sampled at edge k -> o_done high in the cycle after edge k+WIDTH (WIDTH+1 edges). Throughput is one operation per WIDTH+2 cycles.
- i_start is ignored in RUN and DONE; no queuing.
- Operand changes after the accept edge have no effect.
- Boundary cases:
  - A==B with bin=0 gives 0, borrow 0.
  - A==B with bin=1 gives all-ones, borrow 1.
  - A=0, B=all-ones, bin=1 gives 0, borrow 1.
- i_rst during RUN or DONE: at that edge, abort to IDLE with reset values; no o_done for the aborted operation.
- i_rst and i_start both high: reset wins.

Optional Feature:
- RESTADOR_OVERFLOW_EN defined:
  - Adds output o_overflow (1 bit), two's-complement overflow = (A[W-1]^B[W-1]) & (A[W-1]^o_resta[W-1]).
  - A[W-1] and B[W-1] are latched at accept.
  - o_overflow is valid and held with o_resta; reset value 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package restador_pkg:
  - WIDTH_DEF=8.
  - State enum typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Counter width function/constant $clog2(WIDTH).
- Sub-module restador_completo: combinational full-subtractor cell.
  - Inputs i_a, i_b, i_bin; outputs o_resta, o_bout.
  - Instanced once in the serial datapath.

Test Plan:
- Reset, then A=0x5A, B=0x23, bin=0, start 1 cycle -> o_done at edge+9 cycles, o_resta=0x37, o_borrow=0, o_busy high for 9 cycles.
- A=0x00, B=0x01, bin=0 -> o_resta=0xFF, o_borrow=1; A=0x10, B=0x10, bin=1 -> 0xFF, o_borrow=1; A=0x10, B=0x10, bin=0 -> 0x00, o_borrow=0.
- Start accepted with A=0x05, B=0x02; pulse i_start again mid-RUN with A=0xFF -> exactly one o_done, o_resta=0x03.
- Start A=0x80, B=0x01; assert i_rst at cycle 4 -> IDLE, all outputs 0, no o_done; a new start then completes normally.
- RESTADOR_OVERFLOW_EN: A=0x80, B=0x01 -> o_resta=0x7F, o_overflow=1; A=0x7F, B=0x01 -> 0x7E, o_overflow=0.
- Random sweep, 1000 operand/borrow triples checked against a reference model, with back-to-back starts issued the cycle o_busy falls.

Source files
------------

// File: rtl/restador_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package restador_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must reach WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/restador_completo.sv
// Combinational full-subtractor cell: a - b - bin, with borrow-out.
module restador_completo (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_resta,
    output logic o_bout
);

    assign o_resta = i_a ^ i_b ^ i_bin;
    assign o_bout  = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/restador_serial8b.sv
// Bit-serial subtractor A - B - bin, LSB first, one full-subtractor cell.
// Optional two's-complement overflow output enabled by RESTADOR_OVERFLOW_EN.
module restador_serial8b
    import restador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_minuendo,
    input  logic [WIDTH-1:0] i_sustraendo,
    input  logic             i_borrow,
    output logic [WIDTH-1:0] o_resta,
    output logic             o_borrow,
    output logic             o_busy,
`ifdef RESTADOR_OVERFLOW_EN
    output logic             o_overflow,
`endif
    output logic             o_done
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] a_next, b_next;
    logic [WIDTH-2:0] res_reg, res_next;
    logic             br_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] resta_reg;
    logic             borrow_reg;
    logic             bit_d, bit_bout;
    logic             last_bit;
    logic [WIDTH-1:0] result_final;

`ifdef RESTADOR_OVERFLOW_EN
    logic a_msb_reg, b_msb_reg, overflow_reg;
`endif

    restador_completo u_celda (
        .i_a     (a_reg[0]),
        .i_b     (b_reg[0]),
        .i_bin   (br_reg),
        .o_resta (bit_d),
        .o_bout  (bit_bout)
    );

    // Operands shift right; difference bits enter at the top of res_reg.
    // res_reg holds only WIDTH-1 bits: the last bit goes straight to the output.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_op_shift
            assign a_next[gi] = a_reg[gi+1];
            assign b_next[gi] = b_reg[gi+1];
        end
        for (gi = 0; gi < WIDTH - 2; gi++) begin : g_res_shift
            assign res_next[gi] = res_reg[gi+1];
        end
    endgenerate

    assign a_next[WIDTH-1]   = 1'b0;
    assign b_next[WIDTH-1]   = 1'b0;
    assign res_next[WIDTH-2] = bit_d;

    assign last_bit     = (cnt_reg == CNT_W'(WIDTH - 1));
    assign result_final = {bit_d, res_reg};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state_reg)
            RUN:  o_busy = 1'b1;
            DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            resta_reg  <= '0;
            borrow_reg <= 1'b0;
`ifdef RESTADOR_OVERFLOW_EN
            a_msb_reg    <= 1'b0;
            b_msb_reg    <= 1'b0;
            overflow_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        a_reg      <= i_minuendo;
                        b_reg      <= i_sustraendo;
                        br_reg     <= i_borrow;
                        res_reg    <= '0;
                        cnt_reg    <= '0;
                        resta_reg  <= '0;
                        borrow_reg <= 1'b0;
`ifdef RESTADOR_OVERFLOW_EN
                        a_msb_reg    <= i_minuendo[WIDTH-1];
                        b_msb_reg    <= i_sustraendo[WIDTH-1];
                        overflow_reg <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    a_reg   <= a_next;
                    b_reg   <= b_next;
                    res_reg <= res_next;
                    br_reg  <= bit_bout;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_bit) begin
                        resta_reg  <= result_final;
                        borrow_reg <= bit_bout;
`ifdef RESTADOR_OVERFLOW_EN
                        overflow_reg <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ bit_d);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_resta  = resta_reg;
    assign o_borrow = borrow_reg;
`ifdef RESTADOR_OVERFLOW_EN
    assign o_overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_restador_serial8b.sv
// Directed and random checks for restador_serial8b (overflow checks when RESTADOR_OVERFLOW_EN).
module tb_restador_serial8b;

    localparam int WIDTH = 8;

    logic             i_clk;
    logic             i_rst;
    logic             i_start;
    logic [WIDTH-1:0] i_minuendo;
    logic [WIDTH-1:0] i_sustraendo;
    logic             i_borrow;
    logic [WIDTH-1:0] o_resta;
    logic             o_borrow;
    logic             o_busy;
    logic             o_done;
`ifdef RESTADOR_OVERFLOW_EN
    logic             o_overflow;
`endif

    int checks_count = 0;
    int errors_count = 0;

    restador_serial8b #(.WIDTH(WIDTH)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_minuendo   (i_minuendo),
        .i_sustraendo (i_sustraendo),
        .i_borrow     (i_borrow),
        .o_resta      (o_resta),
        .o_borrow     (o_borrow),
        .o_busy       (o_busy),
`ifdef RESTADOR_OVERFLOW_EN
        .o_overflow   (o_overflow),
`endif
        .o_done       (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_count++;
        if (observed !== expected) begin
            errors_count++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Full operation: issue start in the current (idle) cycle, wait for done,
    // end in the idle cycle after done so a new start can follow immediately.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] exp_res, input logic exp_bor, input logic exp_ovf);
        int lat;
        int busy_cycles;
        logic [7:0] got_res;
        logic       got_bor;
        i_minuendo   = a;
        i_sustraendo = b;
        i_borrow     = bin;
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
        i_minuendo   = 8'($urandom);
        i_sustraendo = 8'($urandom);
        i_borrow     = 1'($urandom);
        check_value("cleared_resta", 32'(o_resta), 32'd0);
        check_value("cleared_borrow", 32'(o_borrow), 32'd0);
        lat = 0;
        busy_cycles = o_busy ? 1 : 0;
        while (!o_done && lat < 4 * WIDTH) begin
            tick();
            lat++;
            if (o_busy) busy_cycles++;
        end
        check_value("latency", 32'(lat), 32'(WIDTH));
        check_value("busy_cycles", 32'(busy_cycles), 32'(WIDTH + 1));
        got_res = o_resta;
        got_bor = o_borrow;
        check_value("resta", 32'(got_res), 32'(exp_res));
        check_value("borrow", 32'(got_bor), 32'(exp_bor));
`ifdef RESTADOR_OVERFLOW_EN
        check_value("overflow", 32'(o_overflow), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("overflow model undefined");
`endif
        tick();
        check_value("done_pulse", 32'(o_done), 32'd0);
        check_value("idle_busy", 32'(o_busy), 32'd0);
        check_value("held_resta", 32'(o_resta), 32'(exp_res));
        $display("op a=%02h b=%02h bin=%0d -> resta=%02h borrow=%0d (exp %02h/%0d) lat=%0d",
                 a, b, bin, got_res, got_bor, exp_res, exp_bor, lat);
    endtask

    // Independent arithmetic model: 9-bit unsigned subtraction.
    task automatic run_model_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [8:0] full;
        logic       ovf;
        full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        ovf  = (a[7] ^ b[7]) & (a[7] ^ full[7]);
        run_op(a, b, bin, full[7:0], full[8], ovf);
    endtask

    initial begin
        int dones;
        logic [7:0] done_res;

        i_rst = 1'b1; i_start = 1'b1;
        i_minuendo = 8'hAA; i_sustraendo = 8'h55; i_borrow = 1'b1;
        tick(); tick();
        check_value("rst_busy", 32'(o_busy), 32'd0);
        check_value("rst_done", 32'(o_done), 32'd0);
        check_value("rst_resta", 32'(o_resta), 32'd0);
        check_value("rst_borrow", 32'(o_borrow), 32'd0);
        i_rst = 1'b0; i_start = 1'b0;
        tick();
        check_value("idle_after_rst", 32'(o_busy), 32'd0);

        // Directed vectors, hand-computed
        run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);

        // Start pulsed again mid-RUN must be ignored
        i_minuendo = 8'h05; i_sustraendo = 8'h02; i_borrow = 1'b0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        dones = 0; done_res = 8'h00;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            if (i == 3) begin
                i_minuendo = 8'hFF; i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) begin
                dones++;
                done_res = o_resta;
            end
            tick();
        end
        i_start = 1'b0;
        check_value("midrun_dones", 32'(dones), 32'd1);
        check_value("midrun_resta", 32'(done_res), 32'h03);
        $display("op a=05 b=02 bin=0 with mid-run start -> dones=%0d resta=%02h", dones, done_res);

        // Reset during RUN aborts the operation
        i_minuendo = 8'h80; i_sustraendo = 8'h01; i_borrow = 1'b0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick(); tick(); tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_value("abort_busy", 32'(o_busy), 32'd0);
        check_value("abort_done", 32'(o_done), 32'd0);
        check_value("abort_resta", 32'(o_resta), 32'd0);
        check_value("abort_borrow", 32'(o_borrow), 32'd0);
        dones = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (o_done) dones++;
            tick();
        end
        check_value("abort_no_done", 32'(dones), 32'd0);
        $display("op a=80 b=01 bin=0 aborted by reset -> dones=%0d", dones);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

        // Random sweep, back-to-back starts
        for (int n = 0; n < 1000; n++) begin
            run_model_op(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_count, errors_count);
        $finish;
    end

endmodule
